// File: rtl/signed_div_pow2_round_pipe.sv
// -----------------------------------------------------------------------------
// signed_div_pow2_round_pipe
//
// Two-stage valid/ready pipeline that divides a signed two's-complement operand
// by 2^s. The shift amount and the rounding mode are given per item. An
// arithmetic right shift rounds toward minus infinity. Stage 2 corrects that
// floor quotient for truncate-toward-zero and for round-half-up.
//
// Stage 1 captures the floor quotient q and three flags:
//   sticky : OR of the bits shifted out
//   half   : the most significant bit shifted out
//   sign   : the sign of the operand
// It also captures the mode.
// Stage 2 adds the 0/+1 correction and holds the result for the consumer.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream presents an operand
//   in_ready     block accepts the operand this cycle
//   in_data      signed dividend (N bits)
//   in_shift     divisor exponent s; values >= N are clamped to N-1
//   in_mode      0 floor, 1 truncate toward zero, 2 round half up, 3 floor
//   out_valid    result available
//   out_ready    downstream accepts the result
//   out_data     signed quotient (N bits)
//   out_inexact  1 when any bit shifted out was nonzero
// -----------------------------------------------------------------------------
module signed_div_pow2_round_pipe #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [SW-1:0] in_shift,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_inexact
);

    localparam logic [SW-1:0] SHIFT_MAX = SW'(N - 1);

    localparam logic [1:0] MODE_FLOOR = 2'd0;
    localparam logic [1:0] MODE_TRUNC = 2'd1;
    localparam logic [1:0] MODE_RHU   = 2'd2;

    // -------------------------------------------------------------------------
    // Stage 1 combinational: clamp the shift, then form q, sticky and half
    // -------------------------------------------------------------------------
    logic [SW-1:0] shift_clamped;
    logic [N-1:0]  q_comb;
    logic [N-1:0]  low_mask;
    logic          sticky_comb;
    logic          half_comb;

    always_comb begin
        shift_clamped = in_shift;
        if (in_shift > SHIFT_MAX) begin
            shift_clamped = SHIFT_MAX;
        end
    end

    // Each quotient bit is a mux over every possible shift amount. A source bit
    // that falls off the top of the operand is replaced by the sign bit.
    // This gives the sign extension without using >>>.
    genvar gi, gk;
    generate
        for (gi = 0; gi < N; gi++) begin : g_qbit
            logic [N-1:0] cand;
            for (gk = 0; gk < N; gk++) begin : g_src
                if (gi + gk < N) begin : g_in
                    assign cand[gk] = in_data[gi + gk];
                end else begin : g_ext
                    assign cand[gk] = in_data[N-1];
                end
            end
            assign q_comb[gi] = cand[shift_clamped];

            // Bit gi is shifted out whenever gi < s.
            assign low_mask[gi] = (SW'(gi) < shift_clamped);
        end
    endgenerate

    always_comb begin
        sticky_comb = |(in_data & low_mask);
        half_comb   = 1'b0;
        if (shift_clamped != '0) begin
            half_comb = in_data[shift_clamped - SW'(1)];
        end
    end

    // -------------------------------------------------------------------------
    // Handshake / stage advance
    // -------------------------------------------------------------------------
    logic          s1_valid_reg;
    logic [N-1:0]  s1_q_reg;
    logic          s1_sticky_reg;
    logic          s1_half_reg;
    logic          s1_sign_reg;
    logic [1:0]    s1_mode_reg;

    logic          s2_load;
    logic          s1_load;

    // Stage 2 can take a new value when it is empty or its result is leaving.
    assign s2_load  = !out_valid || out_ready;
    // Stage 1 can take a new value when it is empty or moving into stage 2.
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    // -------------------------------------------------------------------------
    // Stage 1 registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_q_reg      <= '0;
            s1_sticky_reg <= 1'b0;
            s1_half_reg   <= 1'b0;
            s1_sign_reg   <= 1'b0;
            s1_mode_reg   <= MODE_FLOOR;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_q_reg      <= q_comb;
                s1_sticky_reg <= sticky_comb;
                s1_half_reg   <= half_comb;
                s1_sign_reg   <= in_data[N-1];
                s1_mode_reg   <= in_mode;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 combinational: rounding correction
    // -------------------------------------------------------------------------
    // The +1 is applied only when s >= 1. In that case |q| <= 2^(N-2).
    // The N-bit add therefore cannot wrap.
    logic          round_inc;
    logic [N-1:0]  corr_next;

    always_comb begin
        round_inc = 1'b0;
        case (s1_mode_reg)
            MODE_TRUNC: round_inc = s1_sign_reg & s1_sticky_reg;
            MODE_RHU:   round_inc = s1_half_reg;
            default:    round_inc = 1'b0;
        endcase
        corr_next = s1_q_reg + {{(N-1){1'b0}}, round_inc};
    end

    // -------------------------------------------------------------------------
    // Stage 2 registers (output). They hold while the consumer stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_inexact <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data    <= corr_next;
                out_inexact <= s1_sticky_reg;
            end
        end
    end

endmodule

// File: tb/tb_signed_div_pow2_round_pipe.sv
// -----------------------------------------------------------------------------
// tb_signed_div_pow2_round_pipe
//
// Directed checks of signed_div_pow2_round_pipe with N = 8.
// Expected values are computed by hand. The random stream is scored against
// an integer-division model.
// -----------------------------------------------------------------------------
module tb_signed_div_pow2_round_pipe;

    localparam int N      = 8;
    localparam int SW     = 3;
    localparam int N_RAND = 300;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_shift;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_inexact;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [N-1:0] q;
        logic         inx;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    signed_div_pow2_round_pipe #(.N(N), .SW(SW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_shift    (in_shift),
        .in_mode     (in_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: quotient via integer division with explicit mode handling.
    function automatic exp_t model(input logic [N-1:0] a, input int s, input int mode);
        exp_t r;
        int ai, d, tq, rem, fl, x, t, res;
        ai  = int'($signed(a));
        d   = 1 << s;
        tq  = ai / d;
        rem = ai - tq * d;
        fl  = (rem < 0) ? tq - 1 : tq;
        case (mode)
            1: res = tq;
            2: begin
                x = ai + d / 2;
                t = x / d;
                if (x - t * d < 0) t = t - 1;
                res = (s == 0) ? ai : t;
            end
            default: res = fl;
        endcase
        r.q   = res[N-1:0];
        r.inx = (rem != 0);
        return r;
    endfunction

    // Send one item into an empty pipeline and check it at the expected latency.
    task automatic run_one(input logic [N-1:0] a, input logic [SW-1:0] s,
                           input logic [1:0] m, input logic [N-1:0] eq,
                           input logic einx, input string tag);
        out_ready = 1'b1;
        in_data   = a;
        in_shift  = s;
        in_mode   = m;
        in_valid  = 1'b1;
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "/lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "/valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/data"}, 32'(out_data), 32'(eq));
        chk({tag, "/inexact"}, 32'(out_inexact), 32'(einx));
        $display("[TB] item %s a=%h s=%0d mode=%0d -> q=%h inexact=%b",
                 tag, a, s, m, out_data, out_inexact);
        tick();
        chk({tag, "/drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   sent;
        int   rcvd;
        logic [N-1:0] ra;
        logic [SW-1:0] rs;
        logic [1:0] rm;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shift  = '0;
        in_mode   = 2'd0;
        out_ready = 1'b0;

        // Reset state
        #2;
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/out_data", 32'(out_data), 32'd0);
        chk("reset/out_inexact", 32'(out_inexact), 32'd0);
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Rounding modes on -7 / 2
        run_one(8'hF9, 3'd1, 2'd0, 8'hFC, 1'b1, "m7_floor");
        run_one(8'hF9, 3'd1, 2'd1, 8'hFD, 1'b1, "m7_trunc");
        run_one(8'hF9, 3'd1, 2'd2, 8'hFD, 1'b1, "m7_rhu");
        run_one(8'hF9, 3'd1, 2'd3, 8'hFC, 1'b1, "m7_mode3");

        // Positive operand 5 / 2
        run_one(8'h05, 3'd1, 2'd0, 8'h02, 1'b1, "p5_floor");
        run_one(8'h05, 3'd1, 2'd1, 8'h02, 1'b1, "p5_trunc");
        run_one(8'h05, 3'd1, 2'd2, 8'h03, 1'b1, "p5_rhu");

        // Exact division: -8 / 4
        run_one(8'hF8, 3'd2, 2'd0, 8'hFE, 1'b0, "m8_floor");
        run_one(8'hF8, 3'd2, 2'd1, 8'hFE, 1'b0, "m8_trunc");
        run_one(8'hF8, 3'd2, 2'd2, 8'hFE, 1'b0, "m8_rhu");

        // Maximum shift: -127 / 128
        run_one(8'h81, 3'd7, 2'd0, 8'hFF, 1'b1, "s7_floor");
        run_one(8'h81, 3'd7, 2'd1, 8'h00, 1'b1, "s7_trunc");
        run_one(8'h81, 3'd7, 2'd2, 8'hFF, 1'b1, "s7_rhu");

        // s = 0 passes the operand through in every mode
        run_one(8'h80, 3'd0, 2'd0, 8'h80, 1'b0, "s0_floor");
        run_one(8'h80, 3'd0, 2'd1, 8'h80, 1'b0, "s0_trunc");
        run_one(8'h80, 3'd0, 2'd2, 8'h80, 1'b0, "s0_rhu");

        // Back-to-back with backpressure
        out_ready = 1'b0;
        in_shift  = 3'd1;
        in_mode   = 2'd0;
        in_data   = 8'h10;
        in_valid  = 1'b1;
        tick();
        chk("bp/ready_after1", 32'(in_ready), 32'd1);
        in_data = 8'h21;
        tick();
        chk("bp/ready_after2", 32'(in_ready), 32'd0);
        chk("bp/valid", 32'(out_valid), 32'd1);
        chk("bp/data0", 32'(out_data), 32'h08);
        in_data = 8'h32;
        tick();
        chk("bp/stall1_data", 32'(out_data), 32'h08);
        chk("bp/stall1_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp/stall2_data", 32'(out_data), 32'h08);
        chk("bp/stall2_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp/ready_comb", 32'(in_ready), 32'd1);
        tick();
        $display("[TB] item bp1 q=%h", out_data);
        chk("bp/data1", 32'(out_data), 32'h10);
        chk("bp/valid1", 32'(out_valid), 32'd1);
        in_data = 8'h43;
        tick();
        $display("[TB] item bp2 q=%h", out_data);
        chk("bp/data2", 32'(out_data), 32'h19);
        in_valid = 1'b0;
        tick();
        $display("[TB] item bp3 q=%h", out_data);
        chk("bp/data3", 32'(out_data), 32'h21);
        chk("bp/valid3", 32'(out_valid), 32'd1);
        tick();
        chk("bp/empty", 32'(out_valid), 32'd0);

        // Random stream with random valid/ready
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 5000 && rcvd < N_RAND; cyc++) begin
            in_valid = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
            ra = N'($urandom);
            rs = SW'($urandom_range(0, 7));
            rm = 2'($urandom_range(0, 3));
            in_data   = ra;
            in_shift  = rs;
            in_mode   = rm;
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("rand/spurious", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rand/data", 32'(out_data), 32'(e.q));
                    chk("rand/inexact", 32'(out_inexact), 32'(e.inx));
                    $display("[TB] rand item %0d q=%h inexact=%b", rcvd, out_data, out_inexact);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(ra, int'(rs), int'(rm)));
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("rand/received", 32'(rcvd), 32'(N_RAND));
        chk("rand/leftover", 32'(sb.size()), 32'd0);

        // Drain anything still in flight
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        // Reset with two items in flight
        out_ready = 1'b0;
        in_shift  = 3'd1;
        in_mode   = 2'd0;
        in_data   = 8'h40;
        in_valid  = 1'b1;
        tick();
        in_data = 8'h50;
        tick();
        in_valid = 1'b0;
        chk("rst/full_valid", 32'(out_valid), 32'd1);
        chk("rst/full_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst/async_valid", 32'(out_valid), 32'd0);
        chk("rst/async_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst/after_valid", 32'(out_valid), 32'd0);
        chk("rst/after_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rst/after_valid2", 32'(out_valid), 32'd0);
        run_one(8'h0C, 3'd2, 2'd0, 8'h03, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
